// File: rtl/mano_pkg.sv
// mano_pkg: shared definitions for the Mano basic-computer controller.
//   - data_w(): instruction/data word width derived from the address width
//   - OP_*: 3-bit opcode values (OP_REG = register-reference / halt group)
//   - RR_*: register-reference bit positions, highest priority first
//   - state_e: controller states; alu_op_e: ALU operation select
// Optional feature macro used by the importing RTL: MANO_ISZ_EN.
package mano_pkg;

  function automatic int data_w(input int addr_w);
    return addr_w + 4;
  endfunction

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam int RR_CLA = 3;
  localparam int RR_CMA = 2;
  localparam int RR_CIR = 1;
  localparam int RR_CIL = 0;

  typedef enum logic [3:0] {
    S_FETCH0   = 4'd0,
    S_FETCH1   = 4'd1,
    S_FETCH2   = 4'd2,
    S_DECODE   = 4'd3,
    S_INDIRECT = 4'd4,
    S_EXEC0    = 4'd5,
    S_EXEC1    = 4'd6,
    S_EXEC2    = 4'd7,
    S_EXEC3    = 4'd8,
    S_HALT     = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_AND = 3'd1,
    ALU_ADD = 3'd2,
    ALU_LDA = 3'd3,
    ALU_CLA = 3'd4,
    ALU_CMA = 3'd5,
    ALU_CIR = 3'd6,
    ALU_CIL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/mano_alu.sv
// mano_alu: combinational accumulator/link unit for the Mano controller.
// Ports:
//   op_i   operation select (alu_op_e)
//   ac_i   current AC, e_i current E, dr_i current DR
//   ac_o   next AC,    e_o next E (unchanged for ops that do not touch them)
module mano_alu
  import mano_pkg::*;
#(
  parameter int W = 8
) (
  input  alu_op_e        op_i,
  input  logic [W-1:0]   ac_i,
  input  logic           e_i,
  input  logic [W-1:0]   dr_i,
  output logic [W-1:0]   ac_o,
  output logic           e_o
);

  logic [W:0] sum;

  // Operation decode; default passes {E,AC} through unchanged
  always_comb begin
    ac_o = ac_i;
    e_o  = e_i;
    sum  = {1'b0, ac_i} + {1'b0, dr_i};
    case (op_i)
      ALU_AND: ac_o = ac_i & dr_i;
      ALU_ADD: {e_o, ac_o} = sum;
      ALU_LDA: ac_o = dr_i;
      ALU_CLA: ac_o = '0;
      ALU_CMA: ac_o = ~ac_i;
      // rotate {AC,E} right: E enters AC msb, AC lsb goes to E
      ALU_CIR: begin
        ac_o = {e_i, ac_i[W-1:1]};
        e_o  = ac_i[0];
      end
      // rotate left: E enters AC lsb, AC msb goes to E
      ALU_CIL: begin
        ac_o = {ac_i[W-2:0], e_i};
        e_o  = ac_i[W-1];
      end
      default: begin
        ac_o = ac_i;
        e_o  = e_i;
      end
    endcase
  end

endmodule

// File: rtl/mano_control_unit.sv
// mano_control_unit: fetch/decode/execute controller and datapath registers
// (PC, AR, IR, DR, AC, E) of the Mano basic computer, for a single-port RAM
// with synchronous write and 1-cycle read latency.
// Ports:
//   CLK, RST_n (async active-low), RUN (allows a new fetch from FETCH0)
//   mem_addr (= AR), mem_rd, mem_wr, mem_wdata, mem_rdata
//   PC_OUT, AR_OUT, AC_OUT, IR_OUT, E_OUT, halted
// Optional feature: define MANO_ISZ_EN to build opcode 6 as ISZ; otherwise
// opcode 6 is a NOP (after any indirect read) and EXEC3 is never entered.
module mano_control_unit
  import mano_pkg::*;
#(
  parameter  int ADDR_W = 4,
  localparam int DATA_W = data_w(ADDR_W)
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              RUN,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [ADDR_W-1:0] AR_OUT,
  output logic [DATA_W-1:0] AC_OUT,
  output logic [DATA_W-1:0] IR_OUT,
  output logic              E_OUT,
  output logic              halted
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, ar_q;
  logic [DATA_W-1:0] ir_q, dr_q, ac_q;
  logic              e_q;

  logic              i_bit;
  logic [2:0]        opcode;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_ac_d;
  logic              alu_e_d;

  assign i_bit  = ir_q[DATA_W-1];
  assign opcode = ir_q[DATA_W-2:ADDR_W];

  // ALU select: register-ref in DECODE, memory-ref result in EXEC2
  always_comb begin
    alu_op = ALU_NOP;
    if (state_q == S_DECODE && opcode == OP_REG && !i_bit) begin
      if      (ir_q[RR_CLA]) alu_op = ALU_CLA;
      else if (ir_q[RR_CMA]) alu_op = ALU_CMA;
      else if (ir_q[RR_CIR]) alu_op = ALU_CIR;
      else if (ir_q[RR_CIL]) alu_op = ALU_CIL;
      else                   alu_op = ALU_NOP;
    end else if (state_q == S_EXEC2) begin
      case (opcode)
        OP_AND:  alu_op = ALU_AND;
        OP_ADD:  alu_op = ALU_ADD;
        OP_LDA:  alu_op = ALU_LDA;
        default: alu_op = ALU_NOP;
      endcase
    end else begin
      alu_op = ALU_NOP;
    end
  end

  mano_alu #(.W(DATA_W)) u_alu (
    .op_i (alu_op),
    .ac_i (ac_q),
    .e_i  (e_q),
    .dr_i (dr_q),
    .ac_o (alu_ac_d),
    .e_o  (alu_e_d)
  );

  // Memory strobes are pure decodes of state, so an async reset drops them at once
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_FETCH1: mem_rd = 1'b1;
      S_DECODE: mem_rd = i_bit && (opcode != OP_REG);
      S_EXEC0: begin
        case (opcode)
          OP_AND, OP_ADD, OP_LDA: mem_rd = 1'b1;
`ifdef MANO_ISZ_EN
          OP_ISZ: mem_rd = 1'b1;
`endif
          OP_STA: begin
            mem_wr    = 1'b1;
            mem_wdata = ac_q;
          end
          OP_BSA: begin
            mem_wr    = 1'b1;
            mem_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
          end
          default: mem_rd = 1'b0;
        endcase
      end
`ifdef MANO_ISZ_EN
      S_EXEC3: begin
        mem_wr    = 1'b1;
        mem_wdata = dr_q;
      end
`endif
      default: mem_rd = 1'b0;
    endcase
  end

  // Controller FSM and datapath registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_FETCH0;
      pc_q    <= '0;
      ar_q    <= '0;
      ir_q    <= '0;
      dr_q    <= '0;
      ac_q    <= '0;
      e_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH0: begin
          if (RUN) begin
            ar_q    <= pc_q;
            state_q <= S_FETCH1;
          end
        end
        S_FETCH1: begin
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= S_FETCH2;
        end
        S_FETCH2: begin
          ir_q    <= mem_rdata;
          ar_q    <= mem_rdata[ADDR_W-1:0];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode == OP_REG) begin
            if (i_bit) begin
              state_q <= S_HALT;
            end else begin
              ac_q    <= alu_ac_d;
              e_q     <= alu_e_d;
              state_q <= S_FETCH0;
            end
          end else if (i_bit) begin
            state_q <= S_INDIRECT;
          end else begin
            state_q <= S_EXEC0;
          end
        end
        S_INDIRECT: begin
          ar_q    <= mem_rdata[ADDR_W-1:0];
          state_q <= S_EXEC0;
        end
        S_EXEC0: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA: state_q <= S_EXEC1;
`ifdef MANO_ISZ_EN
            OP_ISZ: state_q <= S_EXEC1;
`endif
            OP_BUN: begin
              pc_q    <= ar_q;
              state_q <= S_FETCH0;
            end
            OP_BSA: begin
              ar_q    <= ar_q + ADDR_W'(1);
              state_q <= S_EXEC1;
            end
            default: state_q <= S_FETCH0;
          endcase
        end
        S_EXEC1: begin
          if (opcode == OP_BSA) begin
            pc_q    <= ar_q;
            state_q <= S_FETCH0;
          end else begin
            dr_q    <= mem_rdata;
            state_q <= S_EXEC2;
          end
        end
        S_EXEC2: begin
`ifdef MANO_ISZ_EN
          if (opcode == OP_ISZ) begin
            dr_q    <= dr_q + DATA_W'(1);
            state_q <= S_EXEC3;
          end else begin
            ac_q    <= alu_ac_d;
            e_q     <= alu_e_d;
            state_q <= S_FETCH0;
          end
`else
          ac_q    <= alu_ac_d;
          e_q     <= alu_e_d;
          state_q <= S_FETCH0;
`endif
        end
`ifdef MANO_ISZ_EN
        S_EXEC3: begin
          // skip the next instruction when the incremented word wrapped to zero
          if (dr_q == '0) begin
            pc_q <= pc_q + ADDR_W'(1);
          end
          state_q <= S_FETCH0;
        end
`endif
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH0;
      endcase
    end
  end

  assign mem_addr = ar_q;
  assign PC_OUT   = pc_q;
  assign AR_OUT   = ar_q;
  assign AC_OUT   = ac_q;
  assign IR_OUT   = ir_q;
  assign E_OUT    = e_q;
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_mano_control_unit.sv
// tb_mano_control_unit: directed program tests for mano_control_unit with
// ADDR_W=4 (8-bit words) and a behavioural single-port RAM.
// Works with or without MANO_ISZ_EN defined.
module tb_mano_control_unit;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       RUN = 1'b0;
  logic [3:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [3:0] PC_OUT, AR_OUT;
  logic [7:0] AC_OUT, IR_OUT;
  logic       E_OUT, halted;

  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       ld = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mano_control_unit #(.ADDR_W(4)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .RUN       (RUN),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .PC_OUT    (PC_OUT),
    .AR_OUT    (AR_OUT),
    .AC_OUT    (AC_OUT),
    .IR_OUT    (IR_OUT),
    .E_OUT     (E_OUT),
    .halted    (halted)
  );

  always #5 CLK = ~CLK;

  // RAM: synchronous write, registered read, bulk image load
  always @(posedge CLK) begin
    if (ld) begin
      mem <= img;
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  // hold reset while the image loads, release away from the edge, then RUN
  task automatic start_prog();
    RST_n = 1'b0;
    RUN   = 1'b0;
    ld    = 1'b1;
    tick(1);
    ld    = 1'b0;
    RST_n = 1'b1;
    RUN   = 1'b1;
  endtask

  logic [7:0] rd_trace;

  initial begin
    // ---- reset state ----
    #2;
    check_val("rst_pc", 16'(PC_OUT), 16'h0);
    check_val("rst_ac", 16'(AC_OUT), 16'h0);
    check_val("rst_strobes", {14'h0, mem_rd, mem_wr}, 16'h0);
    check_val("rst_halted", 16'(halted), 16'h0);

    // ---- sum program: LDA A, ADD B, STA C, HLT ----
    clear_img();
    img[0] = 8'h2A; img[1] = 8'h1B; img[2] = 8'h3C; img[3] = 8'hF0;
    img[10] = 8'h25; img[11] = 8'h13;
    start_prog();
    tick(22);
    check_val("sum_not_halted_22", 16'(halted), 16'h0);
    tick(1);
    check_val("sum_halted_23", 16'(halted), 16'h1);
    check_val("sum_ac", 16'(AC_OUT), 16'h38);
    check_val("sum_e", 16'(E_OUT), 16'h0);
    check_val("sum_pc", 16'(PC_OUT), 16'h4);
    check_val("sum_memC", 16'(mem[12]), 16'h38);
    check_val("sum_ir", 16'(IR_OUT), 16'hF0);
    tick(3);
    check_val("halt_stays", {14'h0, halted, mem_rd | mem_wr}, 16'h2);

    // ---- carry and rotate: LDA (F0), ADD (20), CIL, HLT ----
    clear_img();
    img[0] = 8'h2A; img[1] = 8'h1B; img[2] = 8'h71; img[3] = 8'hF0;
    img[10] = 8'hF0; img[11] = 8'h20;
    start_prog();
    tick(14);
    check_val("add_carry_ac", 16'(AC_OUT), 16'h10);
    check_val("add_carry_e", 16'(E_OUT), 16'h1);
    tick(4);
    check_val("cil_ac", 16'(AC_OUT), 16'h21);
    check_val("cil_e", 16'(E_OUT), 16'h0);

    // ---- register-ref: CMA, CIR, CLA, CMA, 7F (CLA wins), HLT ----
    clear_img();
    img[0] = 8'h74; img[1] = 8'h72; img[2] = 8'h78; img[3] = 8'h74;
    img[4] = 8'h7F; img[5] = 8'hF0;
    start_prog();
    tick(4);
    check_val("cma_ac", 16'(AC_OUT), 16'hFF);
    tick(4);
    check_val("cir_ac_e", {7'h0, E_OUT, AC_OUT}, 16'h017F);
    tick(4);
    check_val("cla_ac_e", {7'h0, E_OUT, AC_OUT}, 16'h0100);
    tick(4);
    check_val("cma2_ac", 16'(AC_OUT), 16'hFF);
    tick(4);
    check_val("prio_cla_ac_e", {7'h0, E_OUT, AC_OUT}, 16'h0100);
    tick(4);
    check_val("rr_halted", 16'(halted), 16'h1);

    // ---- indirect LDA I 5 ----
    clear_img();
    img[0] = 8'hA5; img[1] = 8'hF0; img[5] = 8'h09; img[9] = 8'h77;
    start_prog();
    rd_trace = 8'h00;
    for (int k = 0; k < 8; k++) begin
      rd_trace[k] = mem_rd;
      if (k == 7) check_val("ind_ac_before", 16'(AC_OUT), 16'h0);
      tick(1);
    end
    check_val("ind_rd_trace", 16'(rd_trace), 16'h2A);
    check_val("ind_ac", 16'(AC_OUT), 16'h77);
    check_val("ind_ar", 16'(AR_OUT), 16'h9);

    // ---- BSA 8 at address 2 after two NOPs ----
    clear_img();
    img[0] = 8'h70; img[1] = 8'h70; img[2] = 8'h58; img[9] = 8'hF0;
    start_prog();
    tick(8);
    check_val("nop_pc", 16'(PC_OUT), 16'h2);
    tick(6);
    check_val("bsa_pc", 16'(PC_OUT), 16'h9);
    check_val("bsa_mem8", 16'(mem[8]), 16'h03);
    tick(4);
    check_val("bsa_halted_pc", {11'h0, halted, PC_OUT}, 16'h001A);

    // ---- ISZ 6 with mem[6]=FF ----
    clear_img();
    img[0] = 8'h66; img[1] = 8'hF0; img[2] = 8'hF0; img[6] = 8'hFF;
    start_prog();
`ifdef MANO_ISZ_EN
    tick(8);
    check_val("isz_pc", 16'(PC_OUT), 16'h2);
    check_val("isz_mem6", 16'(mem[6]), 16'h00);
    tick(4);
    check_val("isz_halt_pc", {11'h0, halted, PC_OUT}, 16'h0013);
`else
    tick(5);
    check_val("isz_nop_pc", 16'(PC_OUT), 16'h1);
    check_val("isz_nop_mem6", 16'(mem[6]), 16'hFF);
    tick(4);
    check_val("isz_nop_halt_pc", {11'h0, halted, PC_OUT}, 16'h0012);
`endif

    // ---- reset mid-EXEC1 of LDA, restart, RUN=0 hold ----
    clear_img();
    img[0] = 8'h2A; img[1] = 8'hF0; img[10] = 8'h55;
    start_prog();
    tick(5);
    check_val("pre_rst_ar", 16'(AR_OUT), 16'hA);
    #2;
    RST_n = 1'b0;
    #1;
    check_val("midrst_regs", {PC_OUT, AR_OUT, IR_OUT}, 16'h0000);
    check_val("midrst_ac_e", {7'h0, E_OUT, AC_OUT}, 16'h0000);
    check_val("midrst_strobes", {13'h0, halted, mem_rd, mem_wr}, 16'h0);
    #3;
    RST_n = 1'b1;
    tick(1);
    check_val("restart_ar_pc", {8'h0, AR_OUT, PC_OUT}, 16'h0000);
    tick(6);
    check_val("restart_ac", 16'(AC_OUT), 16'h55);
    RUN = 1'b0;
    tick(5);
    check_val("hold_pc_ar", {8'h0, PC_OUT, AR_OUT}, 16'h001A);
    check_val("hold_rd", 16'(mem_rd), 16'h0);
    RUN = 1'b1;
    tick(4);
    check_val("resume_halt", 16'(halted), 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
